// File: rtl/sb_rx_transaction_decoder_if.sv
// Sideband receive bundle: raw sbrx line in, recovered byte and decoded transaction strobes out.
interface sb_rx_transaction_decoder_if #(
  parameter int MAX_BYTES = 8,
  parameter int LEN_W     = 4
);
  logic                   sbrx;
  logic [7:0]             rx_byte;
  logic                   rx_byte_valid;
  logic                   trans_valid;
  logic                   trans_type;
  logic [LEN_W-1:0]       trans_len;
  logic [8*MAX_BYTES-1:0] trans_data;
  logic                   frame_err;
  logic                   crc_err;

  modport master (
    output sbrx,
    input  rx_byte, rx_byte_valid, trans_valid, trans_type, trans_len,
           trans_data, frame_err, crc_err
  );

  modport slave (
    input  sbrx,
    output rx_byte, rx_byte_valid, trans_valid, trans_type, trans_len,
           trans_data, frame_err, crc_err
  );
endinterface

// File: rtl/sb_rx_transaction_decoder.sv
// Sideband RX: oversampled UART byte recovery plus DLE/STX..DLE/ETX transaction parser.
// Optional CRC-16 trailer checking is compiled in with `define SB_RX_CRC_CHECK_EN.
module sb_rx_transaction_decoder #(
  parameter int OVERSAMPLE = 5,
  parameter int MAX_BYTES  = 8,
  parameter int LEN_W      = 4
) (
  input logic                     sb_clk,
  input logic                     rst,
  sb_rx_transaction_decoder_if.slave bus
);
  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int SMP_W  = $clog2(OVERSAMPLE);
  localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);
  localparam logic [7:0] DLE    = 8'hFE;
  localparam logic [7:0] STX_LT = 8'h80;
  localparam logic [7:0] STX_AT = 8'h05;
  localparam logic [7:0] ETX    = 8'h40;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {P_HUNT, P_GOT_DLE, P_PAYLOAD, P_PAY_DLE} parse_state_t;

  logic             r_sync1, r_sync2;
  logic             w_srx;
  bit_state_t       r_bstate;
  logic [SMP_W-1:0] r_sample;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_byte;
  logic             r_rx_valid;
  logic             r_stop_err;
  logic             w_sample_pt;

  parse_state_t     r_pstate;
  logic [LEN_W-1:0] r_count;
  logic [DATA_W-1:0] r_buf, w_buf_next;
  logic             r_cur_type;
  logic             w_do_store;
  logic             r_trans_valid, r_trans_type, r_frame_err;
  logic [LEN_W-1:0] r_trans_len;
  logic [DATA_W-1:0] r_trans_data;

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.sbrx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_srx       = r_sync2;
  assign w_sample_pt = (r_sample == SMP_MID);

  // The detection cycle counts as sample index 0, so the counter restarts at 1.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      r_bstate   <= B_IDLE;
      r_sample   <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_stop_err <= 1'b0;
      if (r_bstate != B_IDLE)
        r_sample <= (r_sample == SMP_LAST) ? '0 : r_sample + 1'b1;
      case (r_bstate)
        B_IDLE: begin
          if (!w_srx) begin
            r_bstate <= B_START;
            r_sample <= SMP_W'(1);
            r_bit    <= '0;
          end
        end
        B_START: begin
          if (w_sample_pt) r_bstate <= w_srx ? B_IDLE : B_DATA;
        end
        B_DATA: begin
          if (w_sample_pt) begin
            r_shift <= {w_srx, r_shift[7:1]};
            if (r_bit == 3'd7) r_bstate <= B_STOP;
            else               r_bit    <= r_bit + 1'b1;
          end
        end
        B_STOP: begin
          if (w_sample_pt) begin
            if (w_srx) begin
              r_rx_byte  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_stop_err <= 1'b1;
            end
            r_bstate <= B_IDLE;
          end
        end
        default: r_bstate <= B_IDLE;
      endcase
    end
  end

  assign w_do_store = r_rx_valid && !r_stop_err &&
                      (((r_pstate == P_PAYLOAD) && (r_rx_byte != DLE)) ||
                       ((r_pstate == P_PAY_DLE) && (r_rx_byte == DLE)));

  always_comb begin
    w_buf_next = r_buf;
    for (int i = 0; i < MAX_BYTES; i++)
      if (LEN_W'(i) == r_count) w_buf_next[i*8 +: 8] = r_rx_byte;
  end

`ifdef SB_RX_CRC_CHECK_EN
  logic [15:0]       r_crc, w_rx_crc;
  logic [7:0]        w_feed_byte;
  logic [DATA_W-1:0] w_data_trim;
  logic              w_crc_ok;
  logic              r_crc_err;

  function automatic logic [15:0] crc16_update(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++)
      v = v[15] ? ({v[14:0], 1'b0} ^ 16'h8005) : {v[14:0], 1'b0};
    return v;
  endfunction

  // CRC runs two bytes behind the store pointer so the trailer never enters it.
  always_comb begin
    w_feed_byte = '0;
    w_rx_crc    = '0;
    w_data_trim = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i + 2 == int'(r_count)) begin
        w_feed_byte    = r_buf[i*8 +: 8];
        w_rx_crc[7:0]  = r_buf[i*8 +: 8];
      end
      if (i + 1 == int'(r_count)) w_rx_crc[15:8] = r_buf[i*8 +: 8];
      if (i + 2 < int'(r_count))  w_data_trim[i*8 +: 8] = r_buf[i*8 +: 8];
    end
  end

  assign w_crc_ok = (r_count >= LEN_W'(2)) && (w_rx_crc == r_crc);
`endif

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      r_pstate      <= P_HUNT;
      r_count       <= '0;
      r_buf         <= '0;
      r_cur_type    <= 1'b0;
      r_trans_valid <= 1'b0;
      r_trans_type  <= 1'b0;
      r_trans_len   <= '0;
      r_trans_data  <= '0;
      r_frame_err   <= 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
      r_crc         <= 16'hFFFF;
      r_crc_err     <= 1'b0;
`endif
    end else begin
      r_trans_valid <= 1'b0;
      r_frame_err   <= 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
      r_crc_err     <= 1'b0;
`endif
      if (r_stop_err) begin
        r_frame_err <= 1'b1;
        r_pstate    <= P_HUNT;
      end else if (w_do_store) begin
        if (r_count == LEN_MAX) begin
          r_frame_err <= 1'b1;
          r_pstate    <= P_HUNT;
        end else begin
          r_buf    <= w_buf_next;
          r_count  <= r_count + 1'b1;
          r_pstate <= P_PAYLOAD;
`ifdef SB_RX_CRC_CHECK_EN
          if (r_count >= LEN_W'(2)) r_crc <= crc16_update(r_crc, w_feed_byte);
`endif
        end
      end else if (r_rx_valid) begin
        case (r_pstate)
          P_HUNT: begin
            if (r_rx_byte == DLE) r_pstate <= P_GOT_DLE;
          end
          P_GOT_DLE: begin
            if ((r_rx_byte == STX_LT) || (r_rx_byte == STX_AT)) begin
              r_pstate   <= P_PAYLOAD;
              r_count    <= '0;
              r_buf      <= '0;
              r_cur_type <= (r_rx_byte == STX_AT);
`ifdef SB_RX_CRC_CHECK_EN
              r_crc      <= crc16_update(16'hFFFF, r_rx_byte);
`endif
            end else if (r_rx_byte != DLE) begin
              r_pstate <= P_HUNT;
            end
          end
          P_PAYLOAD: r_pstate <= P_PAY_DLE;
          P_PAY_DLE: begin
            r_pstate <= P_HUNT;
            if (r_rx_byte == ETX) begin
`ifdef SB_RX_CRC_CHECK_EN
              if (w_crc_ok) begin
                r_trans_valid <= 1'b1;
                r_trans_type  <= r_cur_type;
                r_trans_len   <= r_count - LEN_W'(2);
                r_trans_data  <= w_data_trim;
              end else begin
                r_crc_err <= 1'b1;
              end
`else
              r_trans_valid <= 1'b1;
              r_trans_type  <= r_cur_type;
              r_trans_len   <= r_count;
              r_trans_data  <= r_buf;
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: r_pstate <= P_HUNT;
        endcase
      end
    end
  end

  assign bus.rx_byte       = r_rx_byte;
  assign bus.rx_byte_valid = r_rx_valid;
  assign bus.trans_valid   = r_trans_valid;
  assign bus.trans_type    = r_trans_type;
  assign bus.trans_len     = r_trans_len;
  assign bus.trans_data    = r_trans_data;
  assign bus.frame_err     = r_frame_err;
`ifdef SB_RX_CRC_CHECK_EN
  assign bus.crc_err       = r_crc_err;
`else
  assign bus.crc_err       = 1'b0;
`endif
endmodule

// File: tb/tb_sb_rx_transaction_decoder.sv
// Directed bench for sb_rx_transaction_decoder: serialises frames onto sbrx and checks decoded strobes.
// Frames get a model CRC trailer when SB_RX_CRC_CHECK_EN is defined.
module tb_sb_rx_transaction_decoder;
  localparam int OVS  = 5;
  localparam int MAXB = 8;
  localparam int LW   = 4;

  logic sb_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   nByte = 0, nTrans = 0, nFrameErr = 0, nCrcErr = 0, nExcl = 0;
  int   baseTrans, baseFrame, baseCrc, baseByte;

  sb_rx_transaction_decoder_if #(.MAX_BYTES(MAXB), .LEN_W(LW)) bus ();

  sb_rx_transaction_decoder #(.OVERSAMPLE(OVS), .MAX_BYTES(MAXB), .LEN_W(LW)) dut (
    .sb_clk (sb_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sb_clk = ~sb_clk;

  // Strobe counters sampled on the falling edge, away from register updates.
  always @(negedge sb_clk) begin
    if (bus.rx_byte_valid) nByte++;
    if (bus.trans_valid)   nTrans++;
    if (bus.frame_err)     nFrameErr++;
    if (bus.crc_err)       nCrcErr++;
    if (int'(bus.trans_valid) + int'(bus.frame_err) + int'(bus.crc_err) > 1) nExcl++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    bus.sbrx = 1'b1;
    repeat (n) @(negedge sb_clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    bus.sbrx = 1'b0;
    repeat (OVS) @(negedge sb_clk);
    for (int i = 0; i < 8; i++) begin
      bus.sbrx = b[i];
      repeat (OVS) @(negedge sb_clk);
    end
    bus.sbrx = stopBit;
    repeat (OVS) @(negedge sb_clk);
    bus.sbrx = 1'b1;
  endtask

  task automatic sendStuffed(input logic [7:0] b);
    applyStimulus(b, 1'b1);
    if (b == 8'hFE) applyStimulus(8'hFE, 1'b1);
  endtask

  function automatic logic [15:0] crcModel(input logic [7:0] stx, input logic [63:0] pl, input int n);
    logic [15:0] c;
    logic [7:0]  d;
    logic        fb;
    c = 16'hFFFF;
    for (int j = -1; j < n; j++) begin
      d = (j < 0) ? stx : pl[j*8 +: 8];
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ d[k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  task automatic sendFrame(input logic [7:0] stx, input logic [63:0] pl, input int n, input logic flip);
    logic [15:0] crc;
    crc = crcModel(stx, pl, n);
    if (flip) crc = crc ^ 16'h0001;
    applyStimulus(8'hFE, 1'b1);
    applyStimulus(stx, 1'b1);
    for (int i = 0; i < n; i++) sendStuffed(pl[i*8 +: 8]);
`ifdef SB_RX_CRC_CHECK_EN
    sendStuffed(crc[7:0]);
    sendStuffed(crc[15:8]);
`endif
    applyStimulus(8'hFE, 1'b1);
    applyStimulus(8'h40, 1'b1);
    idle(10);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rx_byte"},     64'(bus.rx_byte),       64'h0);
    checkOutput({tag, "_rx_valid"},    64'(bus.rx_byte_valid), 64'h0);
    checkOutput({tag, "_trans_valid"}, 64'(bus.trans_valid),   64'h0);
    checkOutput({tag, "_trans_type"},  64'(bus.trans_type),    64'h0);
    checkOutput({tag, "_trans_len"},   64'(bus.trans_len),     64'h0);
    checkOutput({tag, "_trans_data"},  bus.trans_data,         64'h0);
    checkOutput({tag, "_frame_err"},   64'(bus.frame_err),     64'h0);
    checkOutput({tag, "_crc_err"},     64'(bus.crc_err),       64'h0);
  endtask

  initial begin
    bus.sbrx = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge sb_clk);
    checkAllZero("reset");
    rst = 1'b1;
    idle(4);

    $display("[TB] LT frame");
    baseTrans = nTrans; baseFrame = nFrameErr;
    sendFrame(8'h80, 64'hC33C, 2, 1'b0);
    checkOutput("lt_count", 64'(nTrans - baseTrans), 64'd1);
    checkOutput("lt_type",  64'(bus.trans_type), 64'd0);
    checkOutput("lt_len",   64'(bus.trans_len),  64'd2);
    checkOutput("lt_data",  bus.trans_data,      64'h0000_0000_0000_C33C);
    checkOutput("lt_rx_byte", 64'(bus.rx_byte),  64'h40);
    checkOutput("lt_no_ferr", 64'(nFrameErr - baseFrame), 64'd0);

    $display("[TB] stuffed AT frame");
    baseTrans = nTrans;
    sendFrame(8'h05, 64'h22FE11, 3, 1'b0);
    checkOutput("stuff_count", 64'(nTrans - baseTrans), 64'd1);
    checkOutput("stuff_type",  64'(bus.trans_type), 64'd1);
    checkOutput("stuff_len",   64'(bus.trans_len),  64'd3);
    checkOutput("stuff_data",  bus.trans_data,      64'h0000_0000_0022_FE11);

    $display("[TB] glitch");
    baseByte = nByte; baseFrame = nFrameErr;
    bus.sbrx = 1'b0;
    @(negedge sb_clk);
    idle(30);
    checkOutput("glitch_bytes", 64'(nByte - baseByte),      64'd0);
    checkOutput("glitch_ferr",  64'(nFrameErr - baseFrame), 64'd0);

    $display("[TB] bad stop bit mid-frame");
    baseTrans = nTrans; baseFrame = nFrameErr;
    applyStimulus(8'hFE, 1'b1);
    applyStimulus(8'h80, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h55, 1'b0);
    idle(10);
    checkOutput("stop_ferr", 64'(nFrameErr - baseFrame), 64'd1);
    applyStimulus(8'hFE, 1'b1);
    applyStimulus(8'h40, 1'b1);
    idle(10);
    checkOutput("stop_no_trans", 64'(nTrans - baseTrans), 64'd0);
    sendFrame(8'h05, 64'hA5, 1, 1'b0);
    checkOutput("recover_count", 64'(nTrans - baseTrans), 64'd1);
    checkOutput("recover_type",  64'(bus.trans_type), 64'd1);
    checkOutput("recover_len",   64'(bus.trans_len),  64'd1);
    checkOutput("recover_data",  bus.trans_data,      64'h0000_0000_0000_00A5);

    $display("[TB] overflow");
    baseTrans = nTrans; baseFrame = nFrameErr;
    applyStimulus(8'hFE, 1'b1);
    applyStimulus(8'h05, 1'b1);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b1);
    idle(5);
    checkOutput("ovf_eight_ok", 64'(nFrameErr - baseFrame), 64'd0);
    applyStimulus(8'h09, 1'b1);
    idle(5);
    checkOutput("ovf_ninth_err", 64'(nFrameErr - baseFrame), 64'd1);
    applyStimulus(8'hFE, 1'b1);
    applyStimulus(8'h40, 1'b1);
    idle(10);
    checkOutput("ovf_tail_ferr",  64'(nFrameErr - baseFrame), 64'd1);
    checkOutput("ovf_tail_trans", 64'(nTrans - baseTrans),     64'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hFE, 1'b1);
    applyStimulus(8'h05, 1'b1);
    applyStimulus(8'h11, 1'b1);
    rst = 1'b0;
    repeat (3) @(negedge sb_clk);
    checkAllZero("midrst");
    rst = 1'b1;
    idle(4);
    baseTrans = nTrans;
    sendFrame(8'h80, 64'hC33C, 2, 1'b0);
    checkOutput("postrst_count", 64'(nTrans - baseTrans), 64'd1);
    checkOutput("postrst_type",  64'(bus.trans_type), 64'd0);
    checkOutput("postrst_len",   64'(bus.trans_len),  64'd2);
    checkOutput("postrst_data",  bus.trans_data,      64'h0000_0000_0000_C33C);

`ifdef SB_RX_CRC_CHECK_EN
    $display("[TB] CRC good and corrupted");
    baseTrans = nTrans; baseCrc = nCrcErr;
    sendFrame(8'h05, 64'h4433_2211, 4, 1'b0);
    checkOutput("crc_good_count", 64'(nTrans - baseTrans), 64'd1);
    checkOutput("crc_good_len",   64'(bus.trans_len), 64'd4);
    checkOutput("crc_good_data",  bus.trans_data,     64'h0000_0000_4433_2211);
    checkOutput("crc_good_noerr", 64'(nCrcErr - baseCrc), 64'd0);
    baseTrans = nTrans; baseFrame = nFrameErr;
    sendFrame(8'h05, 64'h4433_2211, 4, 1'b1);
    checkOutput("crc_bad_err",   64'(nCrcErr - baseCrc),     64'd1);
    checkOutput("crc_bad_trans", 64'(nTrans - baseTrans),    64'd0);
    checkOutput("crc_bad_ferr",  64'(nFrameErr - baseFrame), 64'd0);
`else
    checkOutput("crc_never", 64'(nCrcErr), 64'd0);
`endif
    checkOutput("strobe_exclusive", 64'(nExcl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sb_rx_transaction_decoder.md
# sb_rx_transaction_decoder

Sideband receive path of the logical layer: it oversamples the asynchronous `sbrx` line on `sb_clk`, recovers UART-framed bytes, and assembles them into complete sideband transactions. Input framing is DLE/STX … DLE/ETX with DLE byte-stuffing. It is the receiving counterpart of the sideband transmitter that drives `sbtx`. Decoded transactions go to the lane-initialisation / control FSM as a single-cycle strobe with a packed payload.

## Interface
- `OVERSAMPLE`, 5: `sb_clk` cycles per sideband bit (sideband 1 Mbps, `sb_clk` 5 MHz).
- `MAX_BYTES`, 8: maximum stored bytes per transaction, counted after unstuffing and including CRC bytes when CRC is enabled.
- `LEN_W`, 4: width of `trans_len`; must hold `MAX_BYTES`.

- `sb_clk` in 1: sideband sampling clock.
- `rst` in 1: asynchronous, active-low reset.
- `sbrx` in 1: raw sideband receive line, asynchronous, idle high.
- `rx_byte` out 8: last recovered byte.
- `rx_byte_valid` out 1: one-cycle strobe when `rx_byte` updates.
- `trans_valid` out 1: one-cycle strobe, transaction complete.
- `trans_type` out 1: 0 = LT (STX 8'h80), 1 = AT (STX 8'h05).
- `trans_len` out `LEN_W`: payload byte count.
- `trans_data` out `8*MAX_BYTES`: payload; byte 0 occupies [7:0].
- `frame_err` out 1: one-cycle strobe for a bad stop bit, bad DLE sequence, or overflow.
- `crc_err` out 1: one-cycle strobe for a CRC mismatch. Tied to 0 when CRC checking is not compiled in.

## Operation
- **Input sync:** `sbrx` passes through a 2-flop synchroniser. All logic uses the synchronised value `s_rx`.
- **Bit FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `s_rx`=0 → START, bit counter cleared.
  - START: at sample index `OVERSAMPLE/2` (2), if `s_rx`=1 the low pulse is a glitch → IDLE with no strobe; otherwise → DATA.
  - DATA: 8 bits, LSB first, each sampled at index 2 of its bit period.
  - STOP: sampled at index 2. If 1, `rx_byte_valid` is raised. If 0, `frame_err` is raised and the parser is forced to HUNT. Either way → IDLE immediately, without waiting for the end of the stop bit.
- **Parser FSM states:** HUNT, GOT_DLE, PAYLOAD, PAY_DLE. It advances only on a good byte strobe.
  - HUNT: FE → GOT_DLE; any other byte is ignored.
  - GOT_DLE:
    - 80 → PAYLOAD with type 0.
    - 05 → PAYLOAD with type 1.
    - FE → stay in GOT_DLE.
    - any other byte → HUNT, no error.
  - Entering PAYLOAD clears the count and zeroes the data buffer.
  - PAYLOAD: FE → PAY_DLE; any other byte → store.
  - PAY_DLE:
    - FE → store 8'hFE (unstuffed) → PAYLOAD.
    - 40 (ETX) → complete.
    - any other byte → `frame_err`, → HUNT.
- **Store rule:** a store with count == `MAX_BYTES` raises `frame_err` → HUNT.
- **Complete:** raise `trans_valid`, update `trans_type`/`trans_len`/`trans_data` → HUNT.
- **Output hold:** `trans_*` fields hold until the next `trans_valid`. Unused bytes are zero.
- A zero-length transaction (DLE STX DLE ETX) is valid, with `trans_len`=0.

## Timing
- **Reset values:** all outputs are 0. Bit FSM = IDLE, parser = HUNT. Reset takes effect asynchronously at any point and discards any partial byte or transaction.
- **Byte latency:** `rx_byte_valid` is asserted in the cycle after the stop-bit sample. The stop-bit sample falls 2 sync cycles + 9·`OVERSAMPLE` + 2 cycles after the falling edge of `sbrx`.
- **Transaction latency:** `trans_valid` is asserted exactly 1 cycle after the `rx_byte_valid` of the ETX byte. `frame_err` and `crc_err` obey the same 1-cycle rule relative to the offending byte.
- `trans_valid`, `frame_err` and `crc_err` are mutually exclusive in any cycle.
- **Back-to-back bytes:** a start bit immediately following a stop bit is captured; IDLE is re-entered mid-stop-bit.
- No backpressure: the consumer must sample every strobe.

## Configuration
- `SB_RX_CRC_CHECK_EN` defined:
  - The last two stored bytes are the CRC-16 (poly 16'h8005, init 16'hFFFF, non-reflected), low byte first.
  - The CRC covers the STX byte plus the unstuffed payload, excluding the CRC bytes.
  - At ETX, a stored count < 2 or a CRC mismatch → `crc_err` and no `trans_valid`.
  - On a match, `trans_len` = count−2, and `trans_data` excludes the CRC bytes.
- `SB_RX_CRC_CHECK_EN` undefined: no CRC logic, `crc_err` = 0, and every stored byte is payload.

## Test plan
- **LT frame (no CRC):** FE 80 3C C3 FE 40 → one `trans_valid`, type 0, len 2, `trans_data`[15:0] = 16'hC33C, upper bytes 0.
- **Stuffing:** FE 05 11 FE FE 22 FE 40 → type 1, len 3, `trans_data`[23:0] = 24'h22FE11.
- **Glitch / framing:** a 1-cycle low pulse on `sbrx` → no strobe at all. A byte with stop bit 0 mid-frame → `frame_err`, no `trans_valid`; the next valid frame then decodes correctly.
- **Overflow:** FE 05 followed by 9 non-FE bytes → `frame_err` on the 9th byte. The trailing FE 40 produces nothing.
- **CRC (`SB_RX_CRC_CHECK_EN`):** an AT frame with a model-generated CRC → `trans_valid`, len = payload count. The same frame with one CRC bit flipped → `crc_err` only.
- **Reset mid-frame:** assert `rst` low after FE 05 11, release, then send a full LT frame → all outputs 0 during reset; exactly one `trans_valid` with the LT contents afterwards.
